gcm_ghash_formatter: RTL and testbench
======================================

Name: gcm_ghash_formatter

Overview:
Upstream feeder for the GHASH stage in the AES-GCM datapath.
- Accepts AAD blocks, then ciphertext blocks, each with a byte-valid count.
- Zero-pads partial blocks and accumulates byte lengths.
- Appends the final len(A)||len(C) block with blk_last_o set, giving GHASH a complete, correctly terminated block stream per message.

Parameters:
LEN_W, 64, width of each bit-length field in the length block (GCM fixes 64).
CNT_W, 61, width of internal byte counters (LEN_W-3).

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start_i  input  1  begin new message; sampled only in S_IDLE
has_aad_i  input  1  message carries AAD (sampled with start_i)
has_ct_i  input  1  message carries ciphertext (sampled with start_i)
aad_i  input  128  AAD block, byte 0 at [127:120]
aad_bytes_i  input  5  valid bytes in aad_i (1..16)
aad_last_i  input  1  last AAD block
aad_valid_i  input  1  AAD handshake valid
aad_ready_o  output  1  AAD handshake ready
ct_i  input  128  ciphertext block, byte 0 at [127:120]
ct_bytes_i  input  5  valid bytes in ct_i (1..16)
ct_last_i  input  1  last ciphertext block
ct_valid_i  input  1  ciphertext handshake valid
ct_ready_o  output  1  ciphertext handshake ready
blk_o  output  128  formatted block to GHASH din
blk_last_o  output  1  marks length block (to GHASH last)
blk_valid_o  output  1  output valid
blk_ready_i  input  1  GHASH din_ready
busy_o  output  1  message in progress (state != S_IDLE)
done_o  output  1  one-cycle pulse when length block accepted

Behaviour:
- Reset: all outputs 0; state S_IDLE; counters 0; output register empty.
- States:
  - S_IDLE:
    - start_i → S_AAD if has_aad_i, else S_CT if has_ct_i, else S_LEN.
    - Counters cleared on start.
  - S_AAD:
    - Accept AAD blocks.
    - Accepted block with aad_last_i → S_CT if has_ct, else S_LEN.
  - S_CT:
    - Accept ciphertext blocks.
    - Accepted block with ct_last_i → S_LEN.
  - S_LEN:
    - When output register free, load {aad_bits, ct_bits} with last=1 → S_DONE.
  - S_DONE:
    - Wait for length block handshake (blk_valid_o & blk_ready_i).
    - Pulse done_o that cycle → S_IDLE.
- Output register:
  - Single stage; out_free = !blk_valid_o | blk_ready_i.
  - blk_o, blk_last_o, blk_valid_o held stable while blk_valid_o & !blk_ready_i.
- Input handshakes:
  - aad_ready_o = (state==S_AAD) & out_free.
  - ct_ready_o = (state==S_CT) & out_free.
  - Transfer on valid & ready.
  - Never both ready in the same cycle.
- Latency: transfer at edge N → blk_valid_o high after edge N, i.e. one cycle.
- Throughput: one block per cycle when blk_ready_i held high.
- Padding and counting:
  - Bytes at index ≥ bytes_i are forced to 0.
  - bytes_i = 0 or > 16 is treated as 16.
  - A short non-last block is padded in place, with no realignment; its count is added as given.
  - Byte counters add the effective count per accepted block and wrap modulo 2^CNT_W.
  - Bit length = counter << 3, zero-extended to LEN_W.
- Length block: blk_o = {aad_bits[63:0], ct_bits[63:0]}, blk_last_o = 1. It is the only block with last set.
- Boundary conditions:
  - start_i outside S_IDLE: ignored.
  - Valid on the inactive input: not accepted, no side effect.
  - blk_ready_i low during S_LEN: length block waits; the pending data block drains first.
  - Empty message (no AAD, no CT): exactly one block, all zero, last = 1.
  - Reset mid-message: immediate return to S_IDLE, output register and counters cleared, no done_o.

Decomposition:
- Package gcm_pkg:
  - state_e typedef (S_IDLE, S_AAD, S_CT, S_LEN, S_DONE).
  - Constants GCM_BLK_W=128, GCM_LEN_W=64.
- One natural sub-module: gcm_byte_mask (combinational 5-bit count → 128-bit big-endian byte mask), reusable by the final-block CTR stage.

Test Plan:
- AES-GCM TC2 (no AAD, CT=0388dace60b6a392f328c2b971b2fe78, 16 B) → blocks: that CT (last=0), then 0000000000000000_0000000000000080 (last=1); done_o pulses once.
- AES-GCM TC4: AAD 20 B, CT 60 B.
  - Bytes 16-19 of AAD block 2 kept, rest zeroed.
  - CT block 4: 12 bytes kept, 4 bytes zeroed.
  - Length block 00000000000000a0_00000000000001e0.
- Empty message (has_aad=0, has_ct=0) → single block 128'h0, last=1, one cycle after start.
- Backpressure: blk_ready_i toggled 1,0,0,1 during a 4-block CT stream → blk_o stable while stalled, no block lost or duplicated, ct_ready_o low while out register full and unaccepted.
- start_i asserted in S_CT and aad_valid_i asserted during S_CT → both ignored, counters unchanged.
- Reset asserted after 2 of 4 AAD blocks → outputs 0 immediately; next message TC2 produces the correct length block.

Source files
------------

// File: rtl/gcm_pkg.sv
// Shared types and constants for the AES-GCM datapath blocks.
//   state_e   : GHASH formatter FSM states
//   GCM_BLK_W : AES / GHASH block width in bits
//   GCM_LEN_W : width of each bit-length field in the GCM length block
//   eff_bytes : maps a raw 5-bit byte count to the count actually used
package gcm_pkg;

  localparam int GCM_BLK_W = 128;
  localparam int GCM_LEN_W = 64;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AAD  = 3'd1,
    S_CT   = 3'd2,
    S_LEN  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // A count of 0 or anything above 16 means a full block.
  function automatic logic [4:0] eff_bytes(input logic [4:0] bytes);
    if ((bytes == 5'd0) || (bytes > 5'd16)) begin
      return 5'd16;
    end
    return bytes;
  endfunction

endpackage

// File: rtl/gcm_byte_mask.sv
// Combinational byte-valid mask for a 128-bit big-endian block.
//   bytes_i : number of valid bytes (0 or >16 treated as 16)
//   mask_o  : 8'hff for every valid byte, byte 0 at [127:120]
module gcm_byte_mask
  import gcm_pkg::*;
(
  input  logic [4:0]           bytes_i,
  output logic [GCM_BLK_W-1:0] mask_o
);

  logic [4:0] eff;

  always_comb begin
    eff    = eff_bytes(bytes_i);
    mask_o = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(eff)) begin
        mask_o[GCM_BLK_W-1-8*i -: 8] = 8'hff;
      end
    end
  end

endmodule

// File: rtl/gcm_ghash_formatter.sv
// Feeds GHASH with a complete block stream per message: AAD blocks, then
// ciphertext blocks, each zero-padded past its valid byte count, then the
// len(A)||len(C) block flagged with blk_last_o.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   start_i, has_aad_i, has_ct_i message start and its shape (S_IDLE only)
//   aad_* / ct_*                 input block streams with byte counts
//   blk_o, blk_last_o            formatted output block, length-block marker
//   blk_valid_o, blk_ready_i     output handshake towards GHASH
//   busy_o                       message in progress
//   done_o                       pulses in the cycle the length block is taken
//   dbg_state_o                  current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid must not depend on ready, and once the output block is
// valid it (and its data) is held until blk_ready_i accepts it.
module gcm_ghash_formatter
  import gcm_pkg::*;
#(
  parameter int LEN_W = GCM_LEN_W,
  parameter int CNT_W = LEN_W - 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 has_aad_i,
  input  logic                 has_ct_i,
  input  logic [GCM_BLK_W-1:0] aad_i,
  input  logic [4:0]           aad_bytes_i,
  input  logic                 aad_last_i,
  input  logic                 aad_valid_i,
  output logic                 aad_ready_o,
  input  logic [GCM_BLK_W-1:0] ct_i,
  input  logic [4:0]           ct_bytes_i,
  input  logic                 ct_last_i,
  input  logic                 ct_valid_i,
  output logic                 ct_ready_o,
  output logic [GCM_BLK_W-1:0] blk_o,
  output logic                 blk_last_o,
  output logic                 blk_valid_o,
  input  logic                 blk_ready_i,
  output logic                 busy_o,
  output logic                 done_o,
  output state_e               dbg_state_o
);

  state_e               state_q;
  logic                 has_ct_q;
  logic [CNT_W-1:0]     aad_cnt_q;
  logic [CNT_W-1:0]     ct_cnt_q;
  logic [GCM_BLK_W-1:0] blk_q;
  logic                 blk_last_q;
  logic                 blk_valid_q;

  logic                 out_free;
  logic                 aad_xfer;
  logic                 ct_xfer;
  logic [4:0]           sel_bytes;
  logic [GCM_BLK_W-1:0] sel_mask;
  logic [GCM_BLK_W-1:0] len_blk;

  // The output register can take a new block when it is empty or is being
  // drained in this same cycle.
  assign out_free = !blk_valid_q || blk_ready_i;

  // Ready depends on state, so the two input ports are never ready together.
  assign aad_ready_o = (state_q == S_AAD) && out_free;
  assign ct_ready_o  = (state_q == S_CT) && out_free;
  assign aad_xfer    = aad_valid_i && aad_ready_o;
  assign ct_xfer     = ct_valid_i && ct_ready_o;

  // One mask generator serves both streams, since only one is ever active.
  assign sel_bytes = (state_q == S_AAD) ? aad_bytes_i : ct_bytes_i;

  gcm_byte_mask u_mask (
    .bytes_i (sel_bytes),
    .mask_o  (sel_mask)
  );

  // Byte counts become bit counts by appending three zero bits.
  assign len_blk = {aad_cnt_q, 3'b000, ct_cnt_q, 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      has_ct_q    <= 1'b0;
      aad_cnt_q   <= '0;
      ct_cnt_q    <= '0;
      blk_q       <= '0;
      blk_last_q  <= 1'b0;
      blk_valid_q <= 1'b0;
    end else begin
      // Drain first; any load below in the same cycle overrides this.
      if (blk_ready_i) begin
        blk_valid_q <= 1'b0;
        blk_last_q  <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            has_ct_q  <= has_ct_i;
            aad_cnt_q <= '0;
            ct_cnt_q  <= '0;
            if (has_aad_i) begin
              state_q <= S_AAD;
            end else if (has_ct_i) begin
              state_q <= S_CT;
            end else begin
              state_q <= S_LEN;
            end
          end
        end

        S_AAD: begin
          if (aad_xfer) begin
            blk_q       <= aad_i & sel_mask;
            blk_last_q  <= 1'b0;
            blk_valid_q <= 1'b1;
            aad_cnt_q   <= aad_cnt_q + CNT_W'(eff_bytes(aad_bytes_i));
            if (aad_last_i) begin
              state_q <= has_ct_q ? S_CT : S_LEN;
            end
          end
        end

        S_CT: begin
          if (ct_xfer) begin
            blk_q       <= ct_i & sel_mask;
            blk_last_q  <= 1'b0;
            blk_valid_q <= 1'b1;
            ct_cnt_q    <= ct_cnt_q + CNT_W'(eff_bytes(ct_bytes_i));
            if (ct_last_i) begin
              state_q <= S_LEN;
            end
          end
        end

        S_LEN: begin
          if (out_free) begin
            blk_q       <= len_blk;
            blk_last_q  <= 1'b1;
            blk_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end

        S_DONE: begin
          // The register holds only the length block while in this state.
          if (blk_valid_q && blk_ready_i) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign blk_o       = blk_q;
  assign blk_last_o  = blk_last_q;
  assign blk_valid_o = blk_valid_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE) && blk_valid_q && blk_ready_i;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gcm_ghash_formatter.sv
// Directed testbench for gcm_ghash_formatter: GCM test cases 2 and 4, the
// empty message, output backpressure, ignored inputs and mid-message reset.
module tb_gcm_ghash_formatter;
  import gcm_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         start_i;
  logic         has_aad_i;
  logic         has_ct_i;
  logic [127:0] aad_i;
  logic [4:0]   aad_bytes_i;
  logic         aad_last_i;
  logic         aad_valid_i;
  logic         aad_ready_o;
  logic [127:0] ct_i;
  logic [4:0]   ct_bytes_i;
  logic         ct_last_i;
  logic         ct_valid_i;
  logic         ct_ready_o;
  logic [127:0] blk_o;
  logic         blk_last_o;
  logic         blk_valid_o;
  logic         blk_ready_i;
  logic         busy_o;
  logic         done_o;
  state_e       dbg_state_o;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int done_ref;

  // Expected output blocks as {last, data}, oldest first.
  logic [128:0] exp_q[$];

  gcm_ghash_formatter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .has_aad_i   (has_aad_i),
    .has_ct_i    (has_ct_i),
    .aad_i       (aad_i),
    .aad_bytes_i (aad_bytes_i),
    .aad_last_i  (aad_last_i),
    .aad_valid_i (aad_valid_i),
    .aad_ready_o (aad_ready_o),
    .ct_i        (ct_i),
    .ct_bytes_i  (ct_bytes_i),
    .ct_last_i   (ct_last_i),
    .ct_valid_i  (ct_valid_i),
    .ct_ready_o  (ct_ready_o),
    .blk_o       (blk_o),
    .blk_last_o  (blk_last_o),
    .blk_valid_o (blk_valid_o),
    .blk_ready_i (blk_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted output block must match the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done_o) done_cnt++;
      chk("one_ready", {128'd0, aad_ready_o && ct_ready_o}, 129'd0);
      if (blk_valid_o && blk_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_blk", {blk_last_o, blk_o}, 129'bx);
        end else begin
          chk("blk", {blk_last_o, blk_o}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_msg(input logic a, input logic c);
    has_aad_i = a;
    has_ct_i  = c;
    start_i   = 1'b1;
    step();
    start_i   = 1'b0;
  endtask

  // Presents one block and holds it until the DUT accepts it.
  task automatic send_blk(input bit is_ct, input logic [127:0] d, input logic [4:0] b,
                          input logic last, input logic [127:0] exp_d);
    bit hs = 1'b0;
    int g  = 0;
    if (is_ct) begin
      ct_i = d; ct_bytes_i = b; ct_last_i = last; ct_valid_i = 1'b1;
    end else begin
      aad_i = d; aad_bytes_i = b; aad_last_i = last; aad_valid_i = 1'b1;
    end
    exp_q.push_back({1'b0, exp_d});
    while (!hs && g < 20) begin
      @(negedge clk);
      hs = is_ct ? ct_ready_o : aad_ready_o;
      @(posedge clk);
      #1;
      g++;
    end
    if (is_ct) ct_valid_i = 1'b0;
    else       aad_valid_i = 1'b0;
    chk(is_ct ? "ct_handshake" : "aad_handshake", {128'd0, hs}, 129'd1);
  endtask

  // Waits (bounded) for done_o, then confirms exactly one pulse and an empty queue.
  task automatic wait_done(input int prev, input string tag);
    int g = 0;
    while (done_cnt == prev && g < 40) begin
      @(posedge clk);
      g++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_once"}, 129'(done_cnt), 129'(prev + 1));
    chk({tag, "_drained"}, 129'(exp_q.size()), 129'd0);
    chk({tag, "_idle"}, {128'd0, busy_o}, 129'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; start_i = 0; has_aad_i = 0; has_ct_i = 0;
    aad_i = '0; aad_bytes_i = '0; aad_last_i = 0; aad_valid_i = 0;
    ct_i = '0; ct_bytes_i = '0; ct_last_i = 0; ct_valid_i = 0;
    blk_ready_i = 1'b1;
    #1;
    chk("rst_valid", {128'd0, blk_valid_o}, 129'd0);
    chk("rst_blk", {blk_last_o, blk_o}, 129'd0);
    chk("rst_busy_done", {127'd0, busy_o, done_o}, 129'd0);
    chk("rst_ready", {127'd0, aad_ready_o, ct_ready_o}, 129'd0);
    chk("rst_state", 129'(dbg_state_o), 129'(S_IDLE));
    step(); step();
    rst_n = 1'b1;
    step();

    // TC2: 16 B ciphertext, no AAD.
    done_ref = done_cnt;
    start_msg(1'b0, 1'b1);
    send_blk(1'b1, 128'h0388dace60b6a392f328c2b971b2fe78, 5'd16, 1'b1,
             128'h0388dace60b6a392f328c2b971b2fe78);
    exp_q.push_back({1'b1, 64'h0, 64'h80});
    wait_done(done_ref, "tc2");

    // TC4: 20 B AAD, 60 B ciphertext; junk bytes past the count must be zeroed.
    done_ref = done_cnt;
    start_msg(1'b1, 1'b1);
    send_blk(1'b0, 128'hfeedfacedeadbeeffeedfacedeadbeef, 5'd16, 1'b0,
             128'hfeedfacedeadbeeffeedfacedeadbeef);
    send_blk(1'b0, 128'habaddad2_ffffffff_ffffffff_ffffffff, 5'd4, 1'b1,
             128'habaddad2_00000000_00000000_00000000);
    send_blk(1'b1, 128'h42831ec2217774244b7221b784d0d49c, 5'd16, 1'b0,
             128'h42831ec2217774244b7221b784d0d49c);
    send_blk(1'b1, 128'he3aa212f2c02a4e035c17e2329aca12e, 5'd16, 1'b0,
             128'he3aa212f2c02a4e035c17e2329aca12e);
    send_blk(1'b1, 128'h21d514b25466931c7d8f6a5aac84aa05, 5'd16, 1'b0,
             128'h21d514b25466931c7d8f6a5aac84aa05);
    send_blk(1'b1, 128'h1ba30b396a0aac973d58e091_deadbeef, 5'd12, 1'b1,
             128'h1ba30b396a0aac973d58e091_00000000);
    exp_q.push_back({1'b1, 64'h00000000000000a0, 64'h00000000000001e0});
    wait_done(done_ref, "tc4");

    // Empty message: only the all-zero length block.
    done_ref = done_cnt;
    start_msg(1'b0, 1'b0);
    exp_q.push_back({1'b1, 128'h0});
    wait_done(done_ref, "empty");

    // Backpressure: output stalls for two cycles while the next block waits.
    done_ref = done_cnt;
    start_msg(1'b0, 1'b1);
    send_blk(1'b1, 128'h000102030405060708090a0b0c0d0e0f, 5'd16, 1'b0,
             128'h000102030405060708090a0b0c0d0e0f);
    blk_ready_i = 1'b0;
    ct_i = 128'h101112131415161718191a1b1c1d1e1f; ct_bytes_i = 5'd16; ct_last_i = 1'b0;
    ct_valid_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("bp_ct_ready_low", {128'd0, ct_ready_o}, 129'd0);
      chk("bp_blk_held", {blk_valid_o, blk_o}, {1'b1, 128'h000102030405060708090a0b0c0d0e0f});
      step();
    end
    blk_ready_i = 1'b1;
    send_blk(1'b1, 128'h101112131415161718191a1b1c1d1e1f, 5'd16, 1'b0,
             128'h101112131415161718191a1b1c1d1e1f);
    send_blk(1'b1, 128'h202122232425262728292a2b2c2d2e2f, 5'd16, 1'b0,
             128'h202122232425262728292a2b2c2d2e2f);
    send_blk(1'b1, 128'h303132333435363738393a3b3c3d3e3f, 5'd16, 1'b1,
             128'h303132333435363738393a3b3c3d3e3f);
    exp_q.push_back({1'b1, 64'h0, 64'h200});
    wait_done(done_ref, "bp");

    // Ignored inputs in S_CT; also count 0 and count >16 both mean 16 bytes.
    done_ref = done_cnt;
    start_msg(1'b1, 1'b1);
    send_blk(1'b0, 128'hffeeddccbbaa99887766554433221100, 5'd0, 1'b1,
             128'hffeeddccbbaa99887766554433221100);
    start_i = 1'b1; has_aad_i = 1'b1; has_ct_i = 1'b0;
    aad_i = 128'h55555555555555555555555555555555; aad_bytes_i = 5'd16; aad_last_i = 1'b1;
    aad_valid_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("ign_aad_ready", {128'd0, aad_ready_o}, 129'd0);
      chk("ign_state", 129'(dbg_state_o), 129'(S_CT));
      step();
    end
    start_i = 1'b0; aad_valid_i = 1'b0;
    send_blk(1'b1, 128'hcafebabecafebabecafebabecafebabe, 5'd20, 1'b0,
             128'hcafebabecafebabecafebabecafebabe);
    send_blk(1'b1, 128'h0102030405_ffffffffffffffffffffff, 5'd5, 1'b1,
             128'h0102030405_0000000000000000000000);
    exp_q.push_back({1'b1, 64'h80, 64'ha8});
    wait_done(done_ref, "ign");

    // Reset after two of four AAD blocks, then a clean TC2.
    done_ref = done_cnt;
    start_msg(1'b1, 1'b1);
    send_blk(1'b0, 128'h11111111111111111111111111111111, 5'd16, 1'b0,
             128'h11111111111111111111111111111111);
    send_blk(1'b0, 128'h22222222222222222222222222222222, 5'd16, 1'b0,
             128'h22222222222222222222222222222222);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_blk", {blk_valid_o, blk_o}, 129'd0);
    chk("mid_rst_busy_ready", {126'd0, busy_o, aad_ready_o, ct_ready_o}, 129'd0);
    chk("mid_rst_state", 129'(dbg_state_o), 129'(S_IDLE));
    step(); step();
    chk("mid_rst_no_done", 129'(done_cnt), 129'(done_ref));
    rst_n = 1'b1;
    step();
    start_msg(1'b0, 1'b1);
    send_blk(1'b1, 128'h0388dace60b6a392f328c2b971b2fe78, 5'd16, 1'b1,
             128'h0388dace60b6a392f328c2b971b2fe78);
    exp_q.push_back({1'b1, 64'h0, 64'h80});
    wait_done(done_ref, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
